// File: rtl/fetch_unit_if.sv
// fetch_unit_if: start/redirect control, instruction-memory port and decode-side handshake of the fetch stage
// Signals: start, redirect_valid, redirect_pc  control into fetch
//          mem_adr, mem_rdata                  instruction memory address and returned word
//          out_valid, out_ready, out_instr, out_pc, out_exc  fetch buffer head towards decode
// master: the fetch unit; slave: the surrounding core, memory and decode
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] mem_adr;
  logic [XLEN-1:0] mem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_exc;
  modport master (
    input  start, redirect_valid, redirect_pc, mem_rdata, out_ready,
    output mem_adr, out_valid, out_instr, out_pc, out_exc
  );
  modport slave (
    output start, redirect_valid, redirect_pc, mem_rdata, out_ready,
    input  mem_adr, out_valid, out_instr, out_pc, out_exc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction-memory address and in-order fetch buffer feeding decode
// Ports: clk            clock, all state on the rising edge
//        rst_n          synchronous active-low reset
//        bus (master)   start, redirect_valid/redirect_pc, mem_adr/mem_rdata,
//                       out_valid/out_ready/out_instr/out_pc/out_exc
// Optional: FETCH_MISALIGN_EXC_EN makes a misaligned redirect queue an exception entry and halt fetch;
//           without it the redirect target is forced word-aligned.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            exc;
  } entry_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  entry_t          buf_q [DEPTH];
  entry_t          buf_d [DEPTH];
  logic            pop, fill, misal;
  assign pop  = bus.out_valid & bus.out_ready;
  // a full buffer may still accept a fill when its head leaves in the same cycle
  assign fill = (state_q == RUN) & ~bus.redirect_valid & ((cnt_q < CW'(DEPTH)) | pop);
`ifdef FETCH_MISALIGN_EXC_EN
  assign misal = bus.redirect_valid & (|bus.redirect_pc[1:0]);
`else
  assign misal = 1'b0;
`endif
  assign bus.mem_adr   = pc_q;
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_instr = buf_q[rd_q].instr;
  assign bus.out_pc    = buf_q[rd_q].pc;
  // exc is only ever written as 1 by a misaligned redirect, so without the macro this stays 0
  assign bus.out_exc   = buf_q[rd_q].exc;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (bus.redirect_valid) begin
      // a concurrent pop still completes; everything else in the buffer is discarded
      rd_d    = '0;
      wr_d    = misal ? PW'(1) : '0;
      cnt_d   = misal ? CW'(1) : '0;
      pc_d    = misal ? bus.redirect_pc : bus.redirect_pc & ~XLEN'(3);
      state_d = misal ? HALT : RUN;
      if (misal) buf_d[0] = '{instr: '0, pc: bus.redirect_pc, exc: 1'b1};
    end else begin
      state_d = (state_q == IDLE && bus.start) ? RUN : state_q;
      if (fill) buf_d[wr_q] = '{instr: bus.mem_rdata, pc: pc_q, exc: 1'b0};
      wr_d    = fill ? wr_q + PW'(1) : wr_q;
      pc_d    = fill ? pc_q + XLEN'(4) : pc_q;
      rd_d    = pop ? rd_q + PW'(1) : rd_q;
      cnt_d   = cnt_q + CW'(fill) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      buf_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based reference model checked every cycle
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  fetch_unit_if #(.XLEN(32)) bus();
  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h1111_1111;
      32'h4:   return 32'h2222_2222;
      32'h8:   return 32'h3333_3333;
      default: return ~a;
    endcase
  endfunction
  assign bus.mem_rdata = word(bus.mem_adr);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;
  ent_t        m_q[$];
  logic [31:0] log_pc[$];
  logic [31:0] m_pc;
  int          m_mode;
  logic        m_pop, m_fill, armed = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0;
      m_mode = 0;
      m_q.delete();
      armed = 1'b1;
    end else begin
      m_pop = m_q.size() != 0 && bus.out_ready;
      if (m_pop) log_pc.push_back(m_q[0].pc);
      if (bus.redirect_valid) begin
        m_q.delete();
`ifdef FETCH_MISALIGN_EXC_EN
        if (bus.redirect_pc[1:0] != 2'b00) begin
          m_q.push_back('{bus.redirect_pc, 32'h0, 1'b1});
          m_pc = bus.redirect_pc;
          m_mode = 2;
        end else begin
          m_pc = bus.redirect_pc;
          m_mode = 1;
        end
`else
        m_pc = {bus.redirect_pc[31:2], 2'b00};
        m_mode = 1;
`endif
      end else begin
        m_fill = m_mode == 1 && (m_q.size() < DEPTH || m_pop);
        if (m_pop) void'(m_q.pop_front());
        if (m_fill) begin
          m_q.push_back('{m_pc, word(m_pc), 1'b0});
          m_pc = m_pc + 32'd4;
        end
        if (m_mode == 0 && bus.start) m_mode = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("cmp_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      chk("cmp_mem_adr", bus.mem_adr, m_pc);
      if (m_q.size() != 0) begin
        chk("cmp_pc", bus.out_pc, m_q[0].pc);
        chk("cmp_instr", bus.out_instr, m_q[0].instr);
        chk("cmp_exc", 32'(bus.out_exc), 32'(m_q[0].exc));
      end
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic head(input string name, input logic [31:0] pc, input logic [31:0] instr, input logic exc);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_pc"}, bus.out_pc, pc);
    chk({name, "_instr"}, bus.out_instr, instr);
    chk({name, "_exc"}, 32'(bus.out_exc), 32'(exc));
  endtask
  int n0;
  initial begin
    bus.start = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_mem_adr", bus.mem_adr, 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_exc", 32'(bus.out_exc), 32'd0);
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("start_valid_lat", 32'(bus.out_valid), 32'd0);
    bus.start = 1'b0;
    tick();
    head("seq0", 32'h0, 32'h1111_1111, 1'b0);
    tick();
    head("seq1", 32'h4, 32'h2222_2222, 1'b0);
    tick();
    head("seq2", 32'h8, 32'h3333_3333, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_mem_adr", bus.mem_adr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_mem_adr", bus.mem_adr, 32'h0);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    bus.start = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("bp_mem_adr", bus.mem_adr, 32'h8);
    head("bp_head", 32'h0, 32'h1111_1111, 1'b0);
    n0 = log_pc.size();
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_log_n", log_pc.size(), n0 + 4);
    for (int i = 0; i < 4; i++) chk("bp_log_pc", log_pc[n0+i], 32'(4 * i));
    head("full_head", 32'h10, ~32'h10, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    chk("rd_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_mem_adr", bus.mem_adr, 32'h100);
    chk("rd_popped", log_pc[log_pc.size()-1], 32'h10);
    bus.redirect_valid = 1'b0;
    tick();
    head("rd_head", 32'h100, ~32'h100, 1'b0);
    tick();
    head("rd_next", 32'h104, ~32'h104, 1'b0);
    chk("rd_log_prev", log_pc[log_pc.size()-2], 32'h10);
    chk("rd_log_last", log_pc[log_pc.size()-1], 32'h100);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("wrap_mem_adr0", bus.mem_adr, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    tick();
    chk("wrap_mem_adr1", bus.mem_adr, 32'h0);
    head("wrap_head", 32'hFFFF_FFFC, 32'h3, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    tick();
`ifdef FETCH_MISALIGN_EXC_EN
    head("mis_head", 32'h102, 32'h0, 1'b1);
    bus.redirect_valid = 1'b0;
    tick();
    chk("mis_drain_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("mis_halt_valid", 32'(bus.out_valid), 32'd0);
    chk("mis_halt_mem_adr", bus.mem_adr, 32'h102);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    head("resume_head", 32'h200, ~32'h200, 1'b0);
`else
    chk("mis_valid", 32'(bus.out_valid), 32'd0);
    chk("mis_mem_adr", bus.mem_adr, 32'h100);
    bus.redirect_valid = 1'b0;
    tick();
    head("mis_head", 32'h100, ~32'h100, 1'b0);
`endif
    bus.out_ready = 1'b0;
    repeat (3) tick();
    bus.out_ready = 1'b1;
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the single-port byte-addressed instruction memory. It holds the program counter, drives the memory address every cycle, and captures the 32-bit little-endian word the memory returns on the falling edge. Fetched words go into a small in-order buffer that feeds decode through a valid/ready handshake. Branch and jump redirects flush the buffer.

## Interface
- XLEN, 32, address/data width
- DEPTH, 2, fetch buffer entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, PC loaded at reset

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  leaves IDLE and begins fetching at the current PC
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch target
- mem_adr  out  XLEN  byte address to memory; combinational from pc_q
- mem_rdata  in  XLEN  word at mem_adr, stable before the next rising edge
- out_valid  out  1  buffer head holds a fetched instruction
- out_ready  in  1  decode accepts the head
- out_instr  out  XLEN  instruction word at head
- out_pc  out  XLEN  PC of out_instr
- out_exc  out  1  head entry is a misaligned-fetch marker

## Operation
- State: pc_q, FSM {IDLE, RUN, HALT}, circular buffer of DEPTH entries {instr, pc, exc}, rd_ptr, wr_ptr, count of width $clog2(DEPTH)+1.
- mem_adr = pc_q in every state.
- pop = out_valid & out_ready. out_valid = (count != 0). Head fields are driven from entry rd_ptr.
- fill = (state == RUN) & ~redirect_valid & ((count < DEPTH) | pop). On fill: write {mem_rdata, pc_q, 0} at wr_ptr; pc_q <= pc_q + 4, wrapping modulo 2^XLEN.
- Pointers wrap modulo DEPTH. Count: +1 on fill only, −1 on pop only, unchanged on both.
- FSM:
  - IDLE→RUN when start=1.
  - RUN→HALT on a misaligned redirect (macro on only).
  - HALT→RUN on an aligned redirect.
  - Any state→RUN on an aligned redirect.
  - start is ignored outside IDLE.
- Redirect takes priority over everything:
  - Flush the buffer (count, rd_ptr and wr_ptr ← 0).
  - pc_q <= redirect_pc.
  - No fill that cycle.
  - A pop in the same cycle completes: decode keeps that head. All other entries are discarded.
- HALT: no fills. The buffer drains normally.

## Timing
- Reset values: pc_q=RESET_PC, state=IDLE, count=0, pointers=0, all buffer entries 0. Therefore out_valid=0, out_instr=0, out_pc=0, out_exc=0, mem_adr=RESET_PC.
- Reset asserted mid-operation behaves as a full flush: the next cycle matches the values above.
- Memory latency is half a cycle: the word for mem_adr driven in cycle N is captured at the rising edge ending cycle N.
- Throughput is one instruction per cycle while out_ready=1.
- Start latency: start sampled at edge E0 → first fill at E1 → out_valid=1 after E1.
- Redirect latency: redirect sampled at E0 → pc_q=target after E0 → fill at E1 → out_valid=1 after E1 with out_pc=target.
- Back-pressure: with out_ready=0, the buffer fills to DEPTH and pc_q stops advancing. The same address is re-presented until space frees.
- Full buffer with a pop in the same cycle: fill is allowed and count stays DEPTH.

## Configuration
- FETCH_MISALIGN_EXC_EN defined:
  - A redirect with redirect_pc[1:0] != 0 flushes the buffer and writes a single entry {instr=0, pc=redirect_pc, exc=1} on the redirect edge.
  - FSM enters HALT; pc_q <= redirect_pc.
  - out_exc reflects the head entry's exc field.
- FETCH_MISALIGN_EXC_EN undefined:
  - redirect_pc[1:0] is forced to 2'b00 before loading pc_q.
  - HALT is unreachable and out_exc is tied 0.

## Test plan
- Reset then start at RESET_PC=0, memory words 0x11111111, 0x22222222, 0x33333333 at addresses 0/4/8, out_ready=1 → out_valid rises one cycle after the start edge; outputs (0,0x11111111), (4,0x22222222), (8,0x33333333) on consecutive cycles.
- Back-pressure: out_ready=0 for 5 cycles after start with DEPTH=2 → count saturates at 2, mem_adr holds 0x8. Releasing out_ready → PCs 0,4,8,C delivered with no gaps or duplicates.
- Redirect to 0x100 while the buffer is full and a pop is active in the same cycle → the popped head is delivered; the next out_pc is 0x100 one cycle after the redirect edge; no stale PC appears.
- pc_q=0xFFFFFFFC fetch → next mem_adr=0x00000000 (wrap).
- Macro on: redirect to 0x102 → single entry out_exc=1, out_pc=0x102; no further fills. Then redirect to 0x200 → normal fetch resumes, out_exc=0.
- Macro off: redirect to 0x102 → out_pc=0x100, out_exc=0. Also assert rst_n=0 mid-stream → next cycle out_valid=0, mem_adr=RESET_PC, state IDLE.
